// File: rtl/cost_bcd_converter.sv
// cost_bcd_converter
// ------------------
// Sequential binary-to-BCD converter for the parking-meter cost path. A
// binary cent value is captured on an accepted start strobe and converted by
// shift-and-add-3 (double dabble), one input bit per clock. The result lands
// on bcd/overflow together with a single-cycle done pulse BIN_W+1 cycles
// after the accepting edge.
//
// Parameters:
//   BIN_W   width of the binary input value
//   DIGITS  number of BCD digits produced (max value 10^DIGITS-1)
//
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while busy=0
//   bin       binary value, captured on the edge that accepts start
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/overflow have been updated
//   bcd       result, digit i in bits [4i+3:4i], digit 0 = ones place
//   overflow  value exceeded 10^DIGITS-1 (held until the next done)
//
// Build option:
//   COST_BCD_SAT_EN  when defined, an out-of-range value saturates every
//                    digit to 9 and raises overflow. When undefined, bcd is
//                    bin mod 10^DIGITS, overflow is tied low and the
//                    overflow accumulator does not exist.

module cost_bcd_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  // Working digits after the add-3 correction, and the digits after the
  // following one-bit left shift.
  logic [BCD_W-1:0]   dig_adj;
  logic [BCD_W-1:0]   dig_shift;

`ifdef COST_BCD_SAT_EN
  logic               ovf_acc_q, ovf_acc_d;
  logic               ovf_q, ovf_d;
  logic               carry_out;
  logic [BCD_W-1:0]   sat_val;
`endif

  // Add-3 correction: any digit of 5 or more would become 10 or more after
  // doubling, so pre-adding 3 makes the shift carry correctly into the next
  // digit.
  always_comb begin
    dig_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end else begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4];
      end
    end
  end

  // The MSB of the shift register enters digit 0; the top bit of the top
  // digit falls off, which is what makes the unsaturated result wrap to
  // bin mod 10^DIGITS.
  always_comb begin
    dig_shift = BCD_W'({dig_adj, sr_q[BIN_W-1]});
  end

`ifdef COST_BCD_SAT_EN
  // The bit leaving the top digit is worth 10^DIGITS, so seeing it at all
  // means the value is out of range.
  always_comb begin
    carry_out = dig_adj[BCD_W-1];
    sat_val   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sat_val[4*i +: 4] = 4'd9;
    end
  end
`endif

  // Next-state and datapath control. The counter starts at BIN_W on accept
  // and the last shift is the one taken while it reads 1, so exactly BIN_W
  // shifts happen before FINISH.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
`ifdef COST_BCD_SAT_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef COST_BCD_SAT_EN
          ovf_acc_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        dig_d = dig_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef COST_BCD_SAT_EN
        if (carry_out) begin
          ovf_acc_d = 1'b1;
        end
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // busy drops on this same edge, so start can be accepted during
        // the done cycle.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef COST_BCD_SAT_EN
        ovf_d = ovf_acc_q;
        if (ovf_acc_q) begin
          bcd_d = sat_val;
        end else begin
          bcd_d = dig_q;
        end
`else
        bcd_d = dig_q;
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any conversion in flight
  // without issuing done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef COST_BCD_SAT_EN
  // Overflow accumulator and the registered overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_cost_bcd_converter.sv
// Testbench for cost_bcd_converter. Instance A uses the default geometry
// (14 bits, 4 digits) and is checked every cycle against a timing model and
// a scoreboard of expected results. Instance B uses 20 bits / 6 digits and
// checks latency and result for a couple of values. Honours COST_BCD_SAT_EN.

module tb_cost_bcd_converter;

  localparam int BIN_W_A = 14;
  localparam int DIG_A   = 4;
  localparam int BIN_W_B = 20;
  localparam int DIG_B   = 6;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic                 start_a, busy_a, done_a, overflow_a;
  logic [BIN_W_A-1:0]   bin_a;
  logic [4*DIG_A-1:0]   bcd_a;

  logic                 start_b, busy_b, done_b, overflow_b;
  logic [BIN_W_B-1:0]   bin_b;
  logic [4*DIG_B-1:0]   bcd_b;

  int check_count = 0;
  int pass_count  = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Reference timing model state for instance A.
  bit          m_busy   = 1'b0;
  int          m_cnt    = 0;
  bit          m_done   = 1'b0;
  int          cyc      = 0;
  bit          check_en = 1'b0;

  always #5 clk = ~clk;

  cost_bcd_converter #(.BIN_W(BIN_W_A), .DIGITS(DIG_A)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a),
    .bin      (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .bcd      (bcd_a),
    .overflow (overflow_a)
  );

  cost_bcd_converter #(.BIN_W(BIN_W_B), .DIGITS(DIG_B)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_b),
    .bin      (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .bcd      (bcd_b),
    .overflow (overflow_b)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Expected BCD for a value: decimal digits of value mod 10^digits, or all
  // nines with overflow when saturation is built in and the value is too big.
  function automatic void model_result(input int value, input int digits,
                                       output logic [31:0] exp_bcd,
                                       output logic exp_ovf);
    int modulus;
    int v;
    modulus = 1;
    for (int i = 0; i < digits; i++) modulus = modulus * 10;
    v       = value % modulus;
    exp_bcd = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < digits; i++) begin
      exp_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef COST_BCD_SAT_EN
    if (value >= modulus) begin
      exp_bcd = '0;
      for (int i = 0; i < digits; i++) exp_bcd[4*i +: 4] = 4'd9;
      exp_ovf = 1'b1;
    end
`endif
  endfunction

  // Advance n clock edges, leaving us 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One start pulse on instance A, then enough idle time to finish.
  task automatic applyStimulus(input int value);
    bin_a   = BIN_W_A'(value);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(17);
  endtask

  // Model for instance A: accepts start only when idle, pushes the expected
  // result, and predicts done BIN_W+1 edges after the accepting edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        m_done = 1'b0;
      end else begin
        cyc++;
        m_done = 1'b0;
        if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end else if (start_a) begin
          model_result(int'(bin_a), DIG_A, e.bcd, e.ovf);
          e.cyc = cyc;
          sb_a.push_back(e);
          m_busy = 1'b1;
          m_cnt  = BIN_W_A + 1;
        end
      end
    end
  end

  // Per-cycle checker for instance A, sampled on the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] m_hold;
    logic        m_hold_ovf;
    m_hold     = '0;
    m_hold_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_hold     = '0;
        m_hold_ovf = 1'b0;
        sb_a.delete();
      end
      if (check_en) begin
        checkOutput("a_done", 32'(done_a), 32'(m_done));
        checkOutput("a_busy", 32'(busy_a), 32'(m_busy));
        if (done_a || m_done) begin
          if (sb_a.size() == 0) begin
            checkOutput("a_sb_nonempty_at_done", 32'(sb_a.size()), 32'd1);
          end else begin
            e = sb_a.pop_front();
            checkOutput("a_latency", 32'(cyc - e.cyc), 32'(BIN_W_A + 1));
            m_hold     = e.bcd;
            m_hold_ovf = e.ovf;
          end
        end
        checkOutput("a_bcd", 32'(bcd_a), m_hold);
        checkOutput("a_ovf", 32'(overflow_a), 32'(m_hold_ovf));
      end
    end
  end

  // Instance B: one conversion at a time, bounded wait for done.
  task automatic runWide(input int value);
    exp_t e;
    int   n;
    bit   seen;
    model_result(value, DIG_B, e.bcd, e.ovf);
    e.cyc = 0;
    sb_b.push_back(e);
    bin_b   = BIN_W_B'(value);
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    checkOutput("b_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      e = sb_b.pop_front();
      checkOutput("b_latency", 32'(n), 32'(BIN_W_B + 1));
      checkOutput("b_busy_in_done", 32'(busy_b), 32'd0);
      checkOutput("b_bcd", 32'(bcd_b), e.bcd);
      checkOutput("b_ovf", 32'(overflow_b), 32'(e.ovf));
    end
    tick(3);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    bin_a   = '0;
    start_b = 1'b0;
    bin_b   = '0;
    tick(1);
    check_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Basic conversion.
    applyStimulus(1234);

    // Back-to-back with start held: the second request is taken in the
    // done cycle of the first.
    bin_a   = BIN_W_A'(9999);
    start_a = 1'b1;
    tick(1);
    bin_a = '0;
    tick(16);
    start_a = 1'b0;
    tick(18);

    // Out-of-range value.
    applyStimulus(16383);

    // A start while busy is dropped.
    bin_a   = BIN_W_A'(42);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(4);
    bin_a   = BIN_W_A'(777);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(14);

    // Reset in the middle of a conversion, then a fresh conversion.
    bin_a   = BIN_W_A'(500);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(6);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    applyStimulus(5);

    // Edge values and a few random ones.
    applyStimulus(0);
    applyStimulus(10000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(int'($urandom_range(0, 16383)));
    end

    // Wider geometry.
    runWide(999999);
    runWide(1048575);

    tick(2);
    checkOutput("a_sb_drained", 32'(sb_a.size()), 32'd0);
    checkOutput("b_sb_drained", 32'(sb_b.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
